// File: rtl/xc20xx_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// xc20xx_cfg_ctrl
//
// Configuration controller for the XC20XX CLB array. Takes the serial
// configuration bitstream one bit per DIN_VALID/DIN_READY handshake. It checks
// the "0010" preamble, the 24-bit length count and the per-frame start/stop
// framing. It assembles each frame's FRAME_BITS data bits and issues one
// parallel write per frame into the frame-addressed configuration memory.
//
// Ports:
//   K           clock, all state changes on the rising edge
//   R           synchronous active-high reset
//   DIN         serial configuration bit
//   DIN_VALID   DIN holds a valid bit
//   DIN_READY   controller accepts a bit this cycle (registered)
//   FRAME_DATA  assembled frame; the first-received bit lands in the MSB
//   FRAME_ADDR  target frame index, valid while FRAME_WE is high
//   FRAME_WE    one-cycle frame write strobe
//   DONE        sticky, set with the final frame write
//   ERR         sticky bitstream error
//
// Build option:
//   XC20XX_CFG_STOPCHK_EN  when defined, a 0 among a frame's three stop bits
//                          is an error and that frame is not written. When
//                          undefined, the stop bits are counted but not
//                          checked.
// ---------------------------------------------------------------------------
module xc20xx_cfg_ctrl #(
    parameter  int FRAME_BITS = 46,
    parameter  int NUM_FRAMES = 160,
    localparam int ADDR_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                  K,
    input  logic                  R,
    input  logic                  DIN,
    input  logic                  DIN_VALID,
    output logic                  DIN_READY,
    output logic [FRAME_BITS-1:0] FRAME_DATA,
    output logic [ADDR_W-1:0]     FRAME_ADDR,
    output logic                  FRAME_WE,
    output logic                  DONE,
    output logic                  ERR
);

    localparam int CNT_MAX = (FRAME_BITS > 4) ? FRAME_BITS : 4;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] CNT_PRE_LAST   = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_HSTOP_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0] CNT_DATA_LAST  = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_STOP_LAST  = CNT_W'(2);
    localparam logic [4:0]       LEN_CNT_LAST   = 5'd23;
    localparam logic [ADDR_W-1:0] ADDR_LAST     = ADDR_W'(NUM_FRAMES - 1);
    localparam logic [23:0]      LEN_EXP        = 24'(28 + NUM_FRAMES * (FRAME_BITS + 4));

    typedef enum logic [3:0] {
        IDLE,
        PRE,
        LEN,
        HSTOP,
        FSTART,
        FDATA,
        FSTOP,
        DONE_ST,
        ERR_ST
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [4:0]            len_cnt_q, len_cnt_d;
    logic [23:0]           len_sh_q, len_sh_d;
    logic [FRAME_BITS-1:0] frame_sh_q, frame_sh_d;
    logic [FRAME_BITS-1:0] frame_data_q, frame_data_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  we_q, we_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  ready_q, ready_d;
    logic                  accept;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_cnt_d    = len_cnt_q;
        len_sh_d     = len_sh_q;
        frame_sh_d   = frame_sh_q;
        frame_data_d = frame_data_q;
        we_d         = 1'b0;
        accept       = DIN_VALID && ready_q;

        // The address moves on only after the write strobe has been seen, and
        // never past the last frame.
        addr_d = addr_q;
        if (we_q && (addr_q != ADDR_LAST)) begin
            addr_d = addr_q + 1'b1;
        end

        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (!DIN) begin
                        state_d = PRE;
                        cnt_d   = '0;
                    end
                end
                PRE: begin
                    // Remaining preamble bits are 0,1,0; only the middle one is 1.
                    if (DIN != (cnt_q == CNT_W'(1))) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_PRE_LAST) begin
                        state_d   = LEN;
                        len_cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                LEN: begin
                    len_sh_d = {len_sh_q[22:0], DIN};
                    if (len_cnt_q == LEN_CNT_LAST) begin
                        state_d = (len_sh_d == LEN_EXP) ? HSTOP : ERR_ST;
                        cnt_d   = '0;
                    end else begin
                        len_cnt_d = len_cnt_q + 1'b1;
                    end
                end
                HSTOP: begin
                    if (!DIN) begin
                        state_d = ERR_ST;
                    end else if (cnt_q == CNT_HSTOP_LAST) begin
                        state_d = FSTART;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                FSTART: begin
                    if (DIN) begin
                        state_d = ERR_ST;
                    end else begin
                        // Clearing here keeps a partial frame out of FRAME_DATA.
                        state_d    = FDATA;
                        frame_sh_d = '0;
                        cnt_d      = '0;
                    end
                end
                FDATA: begin
                    frame_sh_d = {frame_sh_q[FRAME_BITS-2:0], DIN};
                    if (cnt_q == CNT_DATA_LAST) begin
                        state_d = FSTOP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                FSTOP: begin
`ifdef XC20XX_CFG_STOPCHK_EN
                    if (!DIN) begin
                        state_d = ERR_ST;
                    end else
`endif
                    if (cnt_q == CNT_STOP_LAST) begin
                        we_d         = 1'b1;
                        frame_data_d = frame_sh_q;
                        state_d      = (addr_q == ADDR_LAST) ? DONE_ST : FSTART;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        // Status flags follow the next state, so they rise together with the
        // final write strobe or one cycle after the offending bit.
        done_d  = (state_d == DONE_ST);
        err_d   = (state_d == ERR_ST);
        ready_d = !(done_d || err_d);
    end

    always_ff @(posedge K) begin
        if (R) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            len_cnt_q    <= '0;
            frame_data_q <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_cnt_q    <= len_cnt_d;
            frame_data_q <= frame_data_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            done_q       <= done_d;
            err_q        <= err_d;
            ready_q      <= ready_d;
        end
        len_sh_q   <= len_sh_d;
        frame_sh_q <= frame_sh_d;
    end

    assign DIN_READY  = ready_q;
    assign FRAME_DATA = frame_data_q;
    assign FRAME_ADDR = addr_q;
    assign FRAME_WE   = we_q;
    assign DONE       = done_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_xc20xx_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_xc20xx_cfg_ctrl
//
// Bench for xc20xx_cfg_ctrl with FRAME_BITS=4, NUM_FRAMES=2. The reference
// model records every accepted bit since reset and re-parses that whole
// history against the bitstream format to decide what the outputs must be.
// ---------------------------------------------------------------------------
module tb_xc20xx_cfg_ctrl;

    localparam int FB = 4;
    localparam int NF = 2;
    localparam int AW = 1;
    localparam logic [23:0] LEN_EXP = 24'(28 + NF * (FB + 4));
`ifdef XC20XX_CFG_STOPCHK_EN
    localparam bit STOPCHK = 1'b1;
`else
    localparam bit STOPCHK = 1'b0;
`endif

    logic          K = 1'b0;
    logic          R = 1'b1;
    logic          DIN = 1'b0;
    logic          DIN_VALID = 1'b0;
    logic          DIN_READY;
    logic [FB-1:0] FRAME_DATA;
    logic [AW-1:0] FRAME_ADDR;
    logic          FRAME_WE;
    logic          DONE;
    logic          ERR;

    xc20xx_cfg_ctrl #(
        .FRAME_BITS(FB),
        .NUM_FRAMES(NF)
    ) dut (
        .K         (K),
        .R         (R),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .DIN_READY (DIN_READY),
        .FRAME_DATA(FRAME_DATA),
        .FRAME_ADDR(FRAME_ADDR),
        .FRAME_WE  (FRAME_WE),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    always #5 K = ~K;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit            err;
        bit            done;
        int            writes;
        logic [FB-1:0] data;
        int            wr_idx;
    } st_t;

    logic acc [0:1023];
    int   n = 0;
    bit   acc_last = 1'b0;
    bit   m_ready = 1'b1;
    st_t  ms;

    // Interpret the accepted bits acc[0..n-1] as a bitstream.
    function automatic st_t parse(input int nb);
        st_t           r;
        int            i;
        int            k;
        int            p;
        int            idx;
        bit            ok;
        logic [23:0]   lv;
        logic [FB-1:0] dat;
        r.err = 1'b0; r.done = 1'b0; r.writes = 0; r.data = '0; r.wr_idx = -1;
        i = 0;
        p = -1;
        while (i < nb && p < 0) begin
            if (acc[i]) begin
                i++;
                continue;
            end
            ok = 1'b1;
            k = 1;
            while (k <= 3 && ok) begin
                if (i + k >= nb) return r;
                if (acc[i + k] != (k == 2)) ok = 1'b0;
                else k++;
            end
            if (ok) p = i + 4;
            else i = i + k + 1;
        end
        if (p < 0) return r;
        if (nb < p + 24) return r;
        lv = '0;
        for (int j = 0; j < 24; j++) lv = {lv[22:0], acc[p + j]};
        if (lv != LEN_EXP) begin
            r.err = 1'b1;
            return r;
        end
        p += 24;
        for (int j = 0; j < 4; j++) begin
            if (p + j >= nb) return r;
            if (!acc[p + j]) begin
                r.err = 1'b1;
                return r;
            end
        end
        p += 4;
        for (int f = 0; f < NF; f++) begin
            if (p >= nb) return r;
            if (acc[p]) begin
                r.err = 1'b1;
                return r;
            end
            dat = '0;
            for (int j = 1; j <= FB; j++) begin
                if (p + j >= nb) return r;
                dat = {dat[FB-2:0], acc[p + j]};
            end
            for (int j = 1; j <= 3; j++) begin
                idx = p + FB + j;
                if (idx >= nb) return r;
                if (STOPCHK && !acc[idx]) begin
                    r.err = 1'b1;
                    return r;
                end
            end
            r.writes = r.writes + 1;
            r.data   = dat;
            r.wr_idx = p + FB + 3;
            if (f == NF - 1) begin
                r.done = 1'b1;
                return r;
            end
            p += FB + 4;
        end
        return r;
    endfunction

    always @(posedge K) begin
        if (R) begin
            n = 0;
            acc_last = 1'b0;
        end else begin
            acc_last = DIN_VALID && m_ready;
            if (acc_last) begin
                acc[n] = DIN;
                n++;
            end
        end
        ms = parse(n);
        m_ready = !(ms.err || ms.done);
    end

    // ---------------- per-cycle compare ----------------
    bit            chk_en = 1'b0;
    bit            we_e;
    int            addr_e;
    logic [FB-1:0] data_e;
    int            wl_addr[$];
    logic [FB-1:0] wl_data[$];

    always @(negedge K) begin
        if (chk_en) begin
            we_e   = acc_last && (ms.writes > 0) && (ms.wr_idx == n - 1);
            addr_e = we_e ? ms.writes - 1 : ((ms.writes > NF - 1) ? NF - 1 : ms.writes);
            data_e = (ms.writes > 0) ? ms.data : '0;
            chk("ready", 32'(DIN_READY), 32'(m_ready));
            chk("we", 32'(FRAME_WE), 32'(we_e));
            chk("addr", 32'(FRAME_ADDR), 32'(addr_e));
            chk("data", 32'(FRAME_DATA), 32'(data_e));
            chk("done", 32'(DONE), 32'(ms.done));
            chk("err", 32'(ERR), 32'(ms.err));
            if (FRAME_WE) begin
                wl_addr.push_back(int'(FRAME_ADDR));
                wl_data.push_back(FRAME_DATA);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic sb [0:255];
    int   slen = 0;

    task automatic clr_s();
        slen = 0;
    endtask

    task automatic add(input logic [31:0] v, input int nb);
        for (int j = nb - 1; j >= 0; j--) begin
            sb[slen] = v[j];
            slen++;
        end
    endtask

    task automatic add_header(input logic [23:0] lenf);
        add(32'hF2, 8);
        add(32'(lenf), 24);
        add(32'hF, 4);
    endtask

    task automatic add_valid();
        add_header(24'h00002C);
        add(32'b0_1010_111, 8);
        add(32'b0_0110_111, 8);
    endtask

    // Presents sb[] bit by bit until all are accepted, the model stops
    // accepting, or stop_at bits have gone in.
    task automatic send(input bit rnd, input int stop_at);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < slen && guard < 3000) begin
            if (!m_ready) break;
            if (stop_at >= 0 && i >= stop_at) break;
            DIN = sb[i];
            DIN_VALID = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge K);
            #1;
            if (acc_last) i++;
            guard++;
        end
        DIN_VALID = 1'b0;
        chk("send_timeout", 32'(guard >= 3000), 32'd0);
    endtask

    task automatic idle(input int c);
        DIN_VALID = 1'b0;
        repeat (c) begin
            @(posedge K);
            #1;
        end
    endtask

    task automatic do_reset(input bit rnd_valid);
        R = 1'b1;
        DIN_VALID = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b0;
        DIN = 1'($urandom_range(0, 1));
        @(posedge K);
        #1;
        R = 1'b0;
        DIN_VALID = 1'b0;
        @(negedge K);
        chk("rst_ready", 32'(DIN_READY), 32'd1);
        chk("rst_data", 32'(FRAME_DATA), 32'd0);
        chk("rst_addr", 32'(FRAME_ADDR), 32'd0);
        chk("rst_we", 32'(FRAME_WE), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        @(posedge K);
        #1;
        wl_addr.delete();
        wl_data.delete();
    endtask

    task automatic check_two_writes(input string tag);
        chk({tag, "_wcount"}, 32'(wl_addr.size()), 32'd2);
        if (wl_addr.size() == 2) begin
            chk({tag, "_addr0"}, 32'(wl_addr[0]), 32'd0);
            chk({tag, "_data0"}, 32'(wl_data[0]), 32'hA);
            chk({tag, "_addr1"}, 32'(wl_addr[1]), 32'd1);
            chk({tag, "_data1"}, 32'(wl_data[1]), 32'h6);
        end
        chk({tag, "_done"}, 32'(DONE), 32'd1);
        chk({tag, "_err"}, 32'(ERR), 32'd0);
        chk({tag, "_ready"}, 32'(DIN_READY), 32'd0);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        repeat (2) @(posedge K);
        #1;
        R = 1'b0;
        chk_en = 1'b1;

        // Valid stream at one bit per cycle.
        do_reset(1'b0);
        clr_s();
        add_valid();
        send(1'b0, -1);
        idle(4);
        check_two_writes("valid");
        chk("valid_model_writes", 32'(ms.writes), 32'd2);
        chk("valid_model_len", 32'(n), 32'd52);

        // Bad length field.
        do_reset(1'b0);
        clr_s();
        add_header(24'h00002D);
        add(32'b0_1010_111, 8);
        send(1'b0, -1);
        idle(4);
        chk("badlen_err", 32'(ERR), 32'd1);
        chk("badlen_ready", 32'(DIN_READY), 32'd0);
        chk("badlen_writes", 32'(wl_addr.size()), 32'd0);
        chk("badlen_accepted", 32'(n), 32'd32);

        // Start bit of 1 after a valid header.
        do_reset(1'b0);
        clr_s();
        add_header(24'h00002C);
        add(32'b1, 1);
        send(1'b0, -1);
        idle(3);
        chk("start1_err", 32'(ERR), 32'd1);
        chk("start1_addr", 32'(FRAME_ADDR), 32'd0);
        chk("start1_writes", 32'(wl_addr.size()), 32'd0);

        // Frame 0 stop bits 101.
        do_reset(1'b0);
        clr_s();
        add_header(24'h00002C);
        add(32'b0_1010_101, 8);
        add(32'b0_0110_111, 8);
        send(1'b0, -1);
        idle(4);
`ifdef XC20XX_CFG_STOPCHK_EN
        chk("stop101_err", 32'(ERR), 32'd1);
        chk("stop101_writes", 32'(wl_addr.size()), 32'd0);
        chk("stop101_done", 32'(DONE), 32'd0);
`else
        check_two_writes("stop101");
`endif

        // Preamble noise, then a valid stream.
        do_reset(1'b0);
        clr_s();
        add(32'b1011, 4);
        add_valid();
        send(1'b0, 4);
        chk("noise_err", 32'(ERR), 32'd0);
        chk("noise_ready", 32'(DIN_READY), 32'd1);
        send(1'b0, -1);
        idle(4);
        check_two_writes("noise");

        // Interrupted stream: random stalls, reset in the middle of frame 1 data.
        do_reset(1'b0);
        clr_s();
        add_valid();
        send(1'b1, 46);
        chk("intr_pre_writes", 32'(wl_addr.size()), 32'd1);
        chk("intr_pre_addr", 32'(FRAME_ADDR), 32'd1);
        do_reset(1'b1);
        idle(2);
        chk("intr_post_writes", 32'(wl_addr.size()), 32'd0);
        send(1'b1, -1);
        idle(4);
        check_two_writes("rerun");

        // Random frame contents and stop bits behind a valid header.
        for (int t = 0; t < 6; t++) begin
            do_reset(1'b0);
            clr_s();
            add_header(24'h00002C);
            for (int f = 0; f < NF; f++) begin
                add(32'b0, 1);
                add(32'($urandom_range(0, 15)), 4);
                for (int s = 0; s < 3; s++) add(32'($urandom_range(0, 3) != 0), 1);
            end
            send(1'b1, -1);
            idle(3);
        end

        // Random noise streams.
        for (int t = 0; t < 4; t++) begin
            do_reset(1'b0);
            clr_s();
            for (int j = 0; j < 60; j++) add(32'($urandom_range(0, 1)), 1);
            send(1'b1, -1);
            idle(3);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/xc20xx_cfg_ctrl.md
# xc20xx_cfg_ctrl

Configuration controller for the XC20XX CLB array. It accepts the serial configuration bitstream one bit per handshake and validates the preamble, length count and frame framing. It assembles each frame's data bits and issues one parallel frame write per frame to the array's frame-addressed configuration memory. That memory holds the F/G truth tables, input-mux selects and storage-element mode bits of every CLB. DONE is raised when the last frame has been written.

## Interface
- FRAME_BITS, 46, data bits per configuration frame
- NUM_FRAMES, 160, frames per bitstream
- ADDR_W, $clog2(NUM_FRAMES), FRAME_ADDR width (derived; not overridden)
- K  input  1  clock; all state changes on rising edge
- R  input  1  reset; synchronous and active-high
- DIN  input  1  serial configuration bit
- DIN_VALID  input  1  DIN holds a valid bit
- DIN_READY  output  1  controller accepts a bit this cycle
- FRAME_DATA  output  FRAME_BITS  assembled frame; first-received bit lands in MSB
- FRAME_ADDR  output  ADDR_W  target frame index for FRAME_WE
- FRAME_WE  output  1  one-cycle frame write strobe
- DONE  output  1  configuration complete (sticky)
- ERR  output  1  bitstream error (sticky)

## Operation
- A bit is accepted when DIN_VALID & DIN_READY are high on a rising K edge.
- DIN_READY is high in every state except DONE_ST and ERR_ST.
- LEN_EXP = 28 + NUM_FRAMES*(FRAME_BITS+4), held in 24 bits. For the defaults this is 8028 = 0x001F5C.
- States and transitions (all transitions occur on an accepted bit):
  - IDLE: a 1 stays in IDLE; a 0 goes to PRE.
  - PRE: expects the 3 bits 0,1,0, completing "0010". Any mismatch returns to IDLE with no ERR.
  - LEN: shifts in 24 bits, MSB first. On the 24th bit, compare with LEN_EXP: equal goes to HSTOP, unequal goes to ERR_ST.
  - HSTOP: expects 4 ones. A 0 goes to ERR_ST. After the 4th one, go to FSTART.
  - FSTART: a 0 goes to FDATA; a 1 goes to ERR_ST.
  - FDATA: shifts FRAME_BITS bits into the frame shift register, then goes to FSTOP.
  - FSTOP: expects 3 stop bits. On the 3rd, latch FRAME_DATA and go to FSTART, or to DONE_ST if this was frame NUM_FRAMES-1.
  - DONE_ST, ERR_ST: terminal until R.
- FRAME_ADDR starts at 0 and increments by 1 in the cycle after each FRAME_WE. It saturates at NUM_FRAMES-1 and never wraps.
- Frame shift register and counters:
  - The frame shift register is cleared on entry to FDATA, so partial data never leaks into FRAME_DATA.
  - A 24-bit length shift register holds LEN.
  - A bit counter in FDATA/FSTOP/HSTOP/PRE is sized to the max of FRAME_BITS and 4.
- An R assertion mid-stream abandons the frame in progress: no FRAME_WE is issued, and the FRAME_ADDR that reset sets to 0 is not advanced.

## Timing
- Reset values: DIN_READY=1, FRAME_DATA=0, FRAME_ADDR=0, FRAME_WE=0, DONE=0, ERR=0, state=IDLE.
- All outputs are registered; there is no combinational path from DIN/DIN_VALID to any output.
- FRAME_WE is high for exactly the one cycle following acceptance of the 3rd stop bit. FRAME_DATA and FRAME_ADDR are valid and stable in that cycle.
- DONE rises in the same cycle as the final FRAME_WE. DIN_READY falls in that same cycle.
- ERR rises in the cycle after the offending bit is accepted. DIN_READY falls with it.
- DIN_VALID low stalls the controller in any state with no state change. Back-to-back bits at one per cycle are sustained indefinitely.
- Total latency from the first preamble 0 to DONE is LEN_EXP+4 accepted bits plus 1 cycle.

## Configuration
- XC20XX_CFG_STOPCHK_EN defined: any 0 received in FSTOP goes to ERR_ST, and no FRAME_WE is issued for that frame.
- XC20XX_CFG_STOPCHK_EN undefined: FSTOP counts 3 bits regardless of value and always writes the frame. HSTOP checking and all other checks are unchanged.

## Test plan
Benches use FRAME_BITS=4, NUM_FRAMES=2, so LEN_EXP=44=0x00002C.
- Valid stream: 1111_0010, 0x00002C, 1111, then frame 0 = 0_1010_111 and frame 1 = 0_0110_111, sent at one bit per cycle.
  - Required: FRAME_WE at addr 0 with data 4'hA; FRAME_WE at addr 1 with data 4'h6.
  - Required: DONE=1 with the 2nd FRAME_WE; ERR=0.
- Bad length field 0x00002D: ERR=1 the cycle after the 24th LEN bit, DIN_READY=0, no FRAME_WE ever.
- Start bit 1 in FSTART after a valid header: ERR=1, FRAME_ADDR stays 0.
- Frame 0 stop bits 101:
  - With XC20XX_CFG_STOPCHK_EN: ERR=1 and no write.
  - Without it: write addr 0 occurs and the run completes with DONE.
- Preamble noise: 1,0,1,1 then a valid stream. The noise returns to IDLE without ERR; the valid stream then completes with DONE.
- Interrupted stream: DIN_VALID toggles randomly; R pulsed mid-FDATA of frame 1, then a full valid stream is sent.
  - Required after R: all outputs reach reset values the next cycle.
  - Required on the rerun: writes at addr 0 and 1, then DONE.
